terminal_writer: RTL and testbench

- Write-side producer for the terminal grid BRAM that character_sprite reads for display.
- Accepts a stream of ASCII characters over a valid/ready handshake and maintains a cursor.
- Turns each character into single-cycle grid writes on tg_write_en/tg_addr/tg_input: glyph, backspace, newline, line clear, full-screen clear.
- Sits between the keyboard/UART front end and character_sprite's write port, in the pixel clock domain.

---
 rtl/terminal_pkg.sv | 19 +
 rtl/terminal_writer.sv | 186 ++++++++++++++++++
 tb/tb_terminal_writer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/terminal_pkg.sv
// Shared terminal grid geometry, control-code constants and the writer state type.
package terminal_pkg;

  localparam int DEF_SCREEN_WIDTH  = 76;
  localparam int DEF_SCREEN_HEIGHT = 44;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR_LINE,
    CLEAR_ALL
  } writer_state_t;

endpackage

// File: rtl/terminal_writer.sv
// Converts an ASCII character stream into single-cell writes on the terminal grid BRAM,
// tracking the cursor and sequencing line and full-screen clears.
module terminal_writer
  import terminal_pkg::*;
#(
  parameter int         SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int         SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter logic [7:0] GLYPH_OFFSET  = 8'h20,
  parameter logic [7:0] BLANK         = 8'h00,
  localparam int        CELLS         = SCREEN_WIDTH * SCREEN_HEIGHT,
  localparam int        AW            = $clog2(CELLS),
  localparam int        XW            = $clog2(SCREEN_WIDTH),
  localparam int        YW            = $clog2(SCREEN_HEIGHT)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  logic          char_valid_in,
  input  logic [7:0]    char_in,
  output logic          char_ready_out,
  output logic          tg_write_en,
  output logic [AW-1:0] tg_addr,
  output logic [7:0]    tg_input,
  output logic [XW-1:0] cursor_x_out,
  output logic [YW-1:0] cursor_y_out,
  output logic          busy_out
);

  // Counter is wide enough to hold CELLS itself so the end-of-clear compare never wraps.
  localparam int             CW     = $clog2(CELLS + 1);
  localparam logic [XW-1:0]  X_LAST = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST = YW'(SCREEN_HEIGHT - 1);

  writer_state_t state, state_n;
  logic [XW-1:0] cursor_x, x_n;
  logic [YW-1:0] cursor_y, y_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          wrap, wrap_n;
  logic          wr_en_n;
  logic [AW-1:0] addr_n;
  logic [7:0]    data_n;
  logic          printable;

  function automatic logic [YW-1:0] next_row(input logic [YW-1:0] y);
    return (y == Y_LAST) ? '0 : y + YW'(1);
  endfunction

  function automatic logic [AW-1:0] row_base(input logic [YW-1:0] y);
    return AW'(y) * AW'(SCREEN_WIDTH);
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return row_base(y) + AW'(x);
  endfunction

  assign printable = (char_in >= 8'h20) && (char_in <= 8'h7E);

  always_comb begin
    state_n = state;
    x_n     = cursor_x;
    y_n     = cursor_y;
    cnt_n   = cnt;
    wrap_n  = wrap;
    wr_en_n = 1'b0;
    addr_n  = tg_addr;
    data_n  = tg_input;
    unique case (state)
      IDLE: begin
        if (char_valid_in) begin
          if (printable) begin
            wr_en_n = 1'b1;
            addr_n  = cell_addr(cursor_x, cursor_y);
            data_n  = char_in - GLYPH_OFFSET;
            state_n = WRITE;
            if (cursor_x == X_LAST) begin
              x_n    = '0;
              y_n    = next_row(cursor_y);
              wrap_n = 1'b1;
            end else begin
              x_n    = cursor_x + XW'(1);
              wrap_n = 1'b0;
            end
          end else begin
            unique case (char_in)
              CH_LF: begin
                x_n     = '0;
                y_n     = next_row(cursor_y);
                wr_en_n = 1'b1;
                addr_n  = row_base(next_row(cursor_y));
                data_n  = BLANK;
                cnt_n   = CW'(1);
                state_n = CLEAR_LINE;
              end
              CH_CR: x_n = '0;
              CH_BS: begin
                // Backspace at the home cell is silently ignored.
                if (cursor_x != '0 || cursor_y != '0) begin
                  if (cursor_x != '0) begin
                    x_n = cursor_x - XW'(1);
                  end else begin
                    x_n = X_LAST;
                    y_n = cursor_y - YW'(1);
                  end
                  wr_en_n = 1'b1;
                  addr_n  = cell_addr(x_n, y_n);
                  data_n  = BLANK;
                  wrap_n  = 1'b0;
                  state_n = WRITE;
                end
              end
              CH_FF: begin
                x_n     = '0;
                y_n     = '0;
                wr_en_n = 1'b1;
                addr_n  = '0;
                data_n  = BLANK;
                cnt_n   = CW'(1);
                state_n = CLEAR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        if (wrap) begin
          wr_en_n = 1'b1;
          addr_n  = row_base(cursor_y);
          data_n  = BLANK;
          cnt_n   = CW'(1);
          state_n = CLEAR_LINE;
        end else begin
          state_n = IDLE;
        end
      end
      CLEAR_LINE: begin
        if (cnt < CW'(SCREEN_WIDTH)) begin
          wr_en_n = 1'b1;
          addr_n  = row_base(cursor_y) + AW'(cnt);
          data_n  = BLANK;
          cnt_n   = cnt + CW'(1);
        end else begin
          state_n = IDLE;
        end
      end
      CLEAR_ALL: begin
        if (cnt < CW'(CELLS)) begin
          wr_en_n = 1'b1;
          addr_n  = AW'(cnt);
          data_n  = BLANK;
          cnt_n   = cnt + CW'(1);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      cursor_x    <= '0;
      cursor_y    <= '0;
      cnt         <= '0;
      wrap        <= 1'b0;
      tg_write_en <= 1'b0;
      tg_addr     <= '0;
      tg_input    <= '0;
    end else begin
      state       <= state_n;
      cursor_x    <= x_n;
      cursor_y    <= y_n;
      cnt         <= cnt_n;
      wrap        <= wrap_n;
      tg_write_en <= wr_en_n;
      tg_addr     <= addr_n;
      tg_input    <= data_n;
    end
  end

  assign char_ready_out = (state == IDLE) && !rst_in;
  assign busy_out       = (state == CLEAR_LINE) || (state == CLEAR_ALL);
  assign cursor_x_out   = cursor_x;
  assign cursor_y_out   = cursor_y;

endmodule

// File: tb/tb_terminal_writer.sv
// Directed scoreboard bench for terminal_writer: expected grid writes are queued as
// characters are sent and matched against every observed write strobe.
module tb_terminal_writer;

  localparam int W     = 76;
  localparam int H     = 44;
  localparam int CELLS = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [7:0]  ch  = 8'h00;
  logic        ready, wr_en, busy;
  logic [11:0] addr;
  logic [7:0]  data;
  logic [6:0]  cx;
  logic [5:0]  cy;

  logic [19:0] q[$];
  logic [19:0] exp_wr;
  bit          sb_en = 1'b1;
  int          total = 0;
  int          bad   = 0;
  int          low_cnt, busy_cnt;

  terminal_writer dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst),
    .char_valid_in (vld),
    .char_in       (ch),
    .char_ready_out(ready),
    .tg_write_en   (wr_en),
    .tg_addr       (addr),
    .tg_input      (data),
    .cursor_x_out  (cx),
    .cursor_y_out  (cy),
    .busy_out      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int a, input logic [7:0] d);
    q.push_back({12'(a), d});
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (sb_en && wr_en === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_write observed addr=%0d expected=none", addr);
      end else begin
        exp_wr = q.pop_front();
        check("wr_addr", 32'(addr), 32'(exp_wr[19:8]));
        check("wr_data", 32'(data), 32'(exp_wr[7:0]));
      end
    end
  end

  task automatic wait_ready(output int low, output int bcnt);
    low  = 0;
    bcnt = 0;
    @(negedge clk);
    while (!ready && low < 5000) begin
      if (busy) bcnt++;
      low++;
      @(negedge clk);
    end
    if (low >= 5000) begin
      total++;
      bad++;
      $error("FAIL ready_timeout observed=low expected=high");
    end
  endtask

  task automatic send(input logic [7:0] c);
    int l, b;
    wait_ready(l, b);
    ch  = c;
    vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_data", 32'(data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_cx", 32'(cx), 0);
    check("rst_cy", 32'(cy), 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 1);

    // Single glyph at home
    push(0, 8'h21);
    send(8'h41);
    @(negedge clk);
    check("A_wr_en", 32'(wr_en), 1);
    check("A_addr", 32'(addr), 0);
    check("A_data", 32'(data), 32'h21);
    check("A_cx", 32'(cx), 1);
    check("A_cy", 32'(cy), 0);

    // Backspace back to home
    push(0, 8'h00);
    send(8'h08);
    wait_ready(low_cnt, busy_cnt);
    check("bs1_cx", 32'(cx), 0);
    check("bs1_cy", 32'(cy), 0);

    // Full row of glyphs, wrap, then clear of row 1
    for (int i = 0; i < W; i++) begin
      push(i, 8'(8'h21 + i) - 8'h20);
      send(8'(8'h21 + i));
    end
    for (int i = 0; i < W; i++) push(W + i, 8'h00);
    wait_ready(low_cnt, busy_cnt);
    check("wrap_busy_cycles", 32'(busy_cnt), W);
    check("wrap_ready_low", 32'(low_cnt), W + 1);
    check("wrap_cx", 32'(cx), 0);
    check("wrap_cy", 32'(cy), 1);

    // Backspace across a line boundary, then at home
    push(W - 1, 8'h00);
    send(8'h08);
    wait_ready(low_cnt, busy_cnt);
    check("bs2_cx", 32'(cx), W - 1);
    check("bs2_cy", 32'(cy), 0);
    send(8'h0D);
    wait_ready(low_cnt, busy_cnt);
    check("cr_cx", 32'(cx), 0);
    send(8'h08);
    @(negedge clk);
    check("bs_home_no_wr", 32'(wr_en), 0);
    check("bs_home_cx", 32'(cx), 0);
    check("bs_home_cy", 32'(cy), 0);

    // Newlines down to the last row, then wrap to the top
    for (int r = 1; r < H; r++) begin
      for (int i = 0; i < W; i++) push(r * W + i, 8'h00);
      send(8'h0A);
    end
    wait_ready(low_cnt, busy_cnt);
    check("lf_bottom_cy", 32'(cy), H - 1);
    for (int i = 0; i < W; i++) push(i, 8'h00);
    send(8'h0A);
    wait_ready(low_cnt, busy_cnt);
    check("lf_wrap_busy", 32'(busy_cnt), W);
    check("lf_wrap_cx", 32'(cx), 0);
    check("lf_wrap_cy", 32'(cy), 0);
    check("lf_drain", 32'(q.size()), 0);

    // Full-screen clear
    push(0, 8'h3A);
    send(8'h5A);
    for (int i = 0; i < CELLS; i++) push(i, 8'h00);
    send(8'h0C);
    wait_ready(low_cnt, busy_cnt);
    check("ff_busy_cycles", 32'(busy_cnt), CELLS);
    check("ff_ready_low", 32'(low_cnt), CELLS);
    check("ff_cx", 32'(cx), 0);
    check("ff_cy", 32'(cy), 0);
    check("ff_drain", 32'(q.size()), 0);

    // Reset in the middle of a full-screen clear
    push(0, 8'h22);
    send(8'h42);
    wait_ready(low_cnt, busy_cnt);
    check("pre_ff_cx", 32'(cx), 1);
    sb_en = 1'b0;
    send(8'h0C);
    low_cnt = 0;
    @(negedge clk);
    while (addr !== 12'd100 && low_cnt < 500) begin
      low_cnt++;
      @(negedge clk);
    end
    check("midclear_reached", 32'(addr), 100);
    #2 rst = 1'b1;
    #1;
    check("midrst_wr_en", 32'(wr_en), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ready", 32'(ready), 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 1);
    check("post_rst_cx", 32'(cx), 0);
    check("post_rst_cy", 32'(cy), 0);
    q.delete();
    sb_en = 1'b1;

    // Unrecognised control code is swallowed
    send(8'h07);
    @(negedge clk);
    check("bel_no_wr", 32'(wr_en), 0);
    check("bel_ready", 32'(ready), 1);
    check("bel_cx", 32'(cx), 0);
    push(0, 8'h22);
    send(8'h42);
    wait_ready(low_cnt, busy_cnt);
    check("final_cx", 32'(cx), 1);
    repeat (3) @(negedge clk);
    check("final_drain", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
